// File: rtl/cpu_alu_arbiter_if.sv
// Request/response and ALU-side bundle for the two-port ALU arbiter.
// The arbiter takes the slave view; the requesters and the ALU model sit on the master view.
interface cpu_alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_op1;
   logic [31:0] req0_op2;
   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_result;

   logic        req1_valid;
   logic        req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_op1;
   logic [31:0] req1_op2;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_result;

   logic [3:0]  alu_op;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [31:0] alu_result;
   logic [31:0] alu_shift_result;
   logic        alu_compare_result;

   logic        busy;

   modport slave (
      input  req0_valid, req0_op, req0_op1, req0_op2, rsp0_ready,
      input  req1_valid, req1_op, req1_op1, req1_op2, rsp1_ready,
      input  alu_result, alu_shift_result, alu_compare_result,
      output req0_ready, rsp0_valid, rsp0_result,
      output req1_ready, rsp1_valid, rsp1_result,
      output alu_op, alu_op1, alu_op2, busy
   );

   modport master (
      output req0_valid, req0_op, req0_op1, req0_op2, rsp0_ready,
      output req1_valid, req1_op, req1_op1, req1_op2, rsp1_ready,
      output alu_result, alu_shift_result, alu_compare_result,
      input  req0_ready, rsp0_valid, rsp0_result,
      input  req1_ready, rsp1_valid, rsp1_result,
      input  alu_op, alu_op1, alu_op2, busy
   );
endinterface

// File: rtl/cpu_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0)
// and the address/branch unit (port 1). One op in flight at a time.
//
// state | meaning
// IDLE  | no op in flight; ready offered to the granted requester
// EXEC  | ALU driven from captured operands, counting down the ALU latency
// RESP  | result held on the owner's response port until accepted
module cpu_alu_arbiter #(
   parameter int ALU_LATENCY = 1
) (
   input logic             i_clock,
   input logic             i_reset,
   cpu_alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

   state_t      state;
   logic        last_grant;
   logic        owner;
   logic [1:0]  cnt;
   logic [3:0]  cap_op;
   logic [31:0] cap_op1;
   logic [31:0] cap_op2;
   logic [31:0] result;

   logic        grant0;
   logic        grant1;
   logic        owner_ready;
   logic        in_resp;
   logic        driving_alu;
   logic [31:0] sel_result;

   // Grant: a lone requester wins; on contention the port not served last wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !i_reset) begin
         if (bus.req0_valid && (!bus.req1_valid || last_grant))
            grant0 = 1'b1;
         else if (bus.req1_valid)
            grant1 = 1'b1;
      end
   end

   // Pick the ALU output that matches the op class; op 15 has no class and yields zero.
   always_comb begin
      sel_result = 32'd0;
      if (cap_op <= 4'd5)
         sel_result = bus.alu_result;
      else if (cap_op <= 4'd8)
         sel_result = bus.alu_shift_result;
      else if (cap_op <= 4'd14)
         sel_result = {31'b0, bus.alu_compare_result};
   end

   assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

   // Arbitration FSM: capture on handshake, wait out the ALU, hold the response.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         cnt        <= 2'd0;
         cap_op     <= 4'd0;
         cap_op1    <= 32'd0;
         cap_op2    <= 32'd0;
         result     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  owner      <= grant1;
                  last_grant <= grant1;
                  cap_op     <= grant1 ? bus.req1_op  : bus.req0_op;
                  cap_op1    <= grant1 ? bus.req1_op1 : bus.req0_op1;
                  cap_op2    <= grant1 ? bus.req1_op2 : bus.req0_op2;
                  cnt        <= CNT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 2'd0) begin
                  result <= sel_result;
                  state  <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (owner_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_resp     = (state == RESP);
   assign driving_alu = (state != IDLE);

   assign bus.req0_ready  = grant0;
   assign bus.req1_ready  = grant1;
   assign bus.rsp0_valid  = in_resp && !owner;
   assign bus.rsp1_valid  = in_resp && owner;
   assign bus.rsp0_result = (in_resp && !owner) ? result : 32'd0;
   assign bus.rsp1_result = (in_resp && owner)  ? result : 32'd0;
   // Captured operands stay in their registers after an op; gate them so IDLE shows zeros.
   assign bus.alu_op  = driving_alu ? cap_op  : 4'd0;
   assign bus.alu_op1 = driving_alu ? cap_op1 : 32'd0;
   assign bus.alu_op2 = driving_alu ? cap_op2 : 32'd0;
   assign bus.busy    = driving_alu;

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Bench for cpu_alu_arbiter: a latency-1 instance for the table, contention and
// backpressure sequences, and a latency-3 instance for latency and mid-op reset.
module tb_cpu_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1;
   logic rst3;

   cpu_alu_arbiter_if a ();
   cpu_alu_arbiter_if b ();

   cpu_alu_arbiter #(.ALU_LATENCY(1)) dut1 (.i_clock(clk), .i_reset(rst1), .bus(a.slave));
   cpu_alu_arbiter #(.ALU_LATENCY(3)) dut3 (.i_clock(clk), .i_reset(rst3), .bus(b.slave));

   int total = 0;
   int bad   = 0;

   // ALU model: every output computes something for every op, so a wrong
   // selection in the arbiter shows up as a wrong result.
   function automatic logic [31:0] f_arith(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         4'd0: return x + y;
         4'd1: return x - y;
         4'd2: return x & y;
         4'd3: return x | y;
         4'd4: return x ^ y;
         4'd5: return {31'b0, $signed(x) < $signed(y)};
         default: return x ^ y ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   function automatic logic [31:0] f_shift(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx;
      sx = x;
      case (op)
         4'd6: return x << y[4:0];
         4'd7: return x >> y[4:0];
         4'd8: return sx >>> y[4:0];
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic f_cmp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         4'd9:  return $signed(x) < $signed(y);
         4'd10: return x < y;
         4'd11: return x == y;
         4'd12: return x != y;
         4'd13: return $signed(x) >= $signed(y);
         4'd14: return x >= y;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      a.alu_result         = f_arith(a.alu_op, a.alu_op1, a.alu_op2);
      a.alu_shift_result   = f_shift(a.alu_op, a.alu_op1, a.alu_op2);
      a.alu_compare_result = f_cmp(a.alu_op, a.alu_op1, a.alu_op2);
      b.alu_result         = f_arith(b.alu_op, b.alu_op1, b.alu_op2);
      b.alu_shift_result   = f_shift(b.alu_op, b.alu_op1, b.alu_op2);
      b.alu_compare_result = f_cmp(b.alu_op, b.alu_op1, b.alu_op2);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out", nm);
   endtask

   // Scoreboard for dut1: pushed at the request handshake, popped at the response handshake.
   typedef struct {
      logic        port;
      logic [31:0] res;
   } exp_t;
   exp_t sbq[$];
   int rsp_cnt0 = 0;
   int rsp_cnt1 = 0;

   task automatic sb_pop(input logic p, input logic [31:0] r);
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb_unexpected: response on port %0d result %h with nothing outstanding", p, r);
      end else begin
         e = sbq.pop_front();
         check("sb_port", 64'(p), 64'(e.port));
         check("sb_result", 64'(r), 64'(e.res));
      end
   endtask

   always @(negedge clk) begin
      if (!rst1) begin
         if (a.rsp0_valid && a.rsp0_ready) begin
            rsp_cnt0++;
            sb_pop(1'b0, a.rsp0_result);
         end
         if (a.rsp1_valid && a.rsp1_ready) begin
            rsp_cnt1++;
            sb_pop(1'b1, a.rsp1_result);
         end
         if (a.req0_ready || a.req1_ready)
            check("one_ready", 64'(a.req0_ready & a.req1_ready), 64'(0));
      end
   end

   task automatic set_req(input logic p, input logic v, input logic [3:0] op,
                          input logic [31:0] x, input logic [31:0] y);
      if (!p) begin
         a.req0_valid = v; a.req0_op = op; a.req0_op1 = x; a.req0_op2 = y;
      end else begin
         a.req1_valid = v; a.req1_op = op; a.req1_op1 = x; a.req1_op2 = y;
      end
   endtask

   function automatic logic rdy(input logic p);
      return p ? a.req1_ready : a.req0_ready;
   endfunction

   function automatic logic rv(input logic p);
      return p ? a.rsp1_valid : a.rsp0_valid;
   endfunction

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         timeout(nm);
         sbq.delete();
      end
   endtask

   // One op on dut1 through the full handshake; checks capture and latency.
   task automatic run_op(input logic p, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      bit got;
      int lat;
      got = 0;
      set_req(p, 1'b1, op, x, y);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rdy(p)) got = 1;
      end
      if (!got) begin
         timeout("req_ready");
         set_req(p, 1'b0, 4'd0, 32'd0, 32'd0);
         return;
      end
      sbq.push_back('{p, exp});
      @(posedge clk); #1;
      set_req(p, 1'b0, 4'hF, 32'hBAD0_0000, 32'hBAD0_0001);
      @(negedge clk);
      check("capture", {28'd0, a.alu_op, a.alu_op1}, {28'd0, op, x});
      check("capture_op2", 64'(a.alu_op2), 64'(y));
      for (lat = 1; lat < 20; lat++) begin
         if (rv(p)) break;
         @(negedge clk);
      end
      check("latency", 64'(lat), 64'(2));
      check("other_rsp_idle", 64'(rv(!p)), 64'(0));
      wait_drain("rsp_drain");
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        port;
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[11];

   initial begin
      bit seen;
      int lat;
      int k0, k1, n0, n1, base0, base1, hp, cnt_grants;
      bit pend;
      logic [63:0] pend_v;
      logic gq[$];

      vt[0]  = '{1'b0, 4'd0,  32'd5,         32'hFFFF_FFFD, 32'h0000_0002};
      vt[1]  = '{1'b1, 4'd8,  32'h8000_0000, 32'd4,         32'hF800_0000};
      vt[2]  = '{1'b1, 4'd7,  32'h8000_0000, 32'd4,         32'h0800_0000};
      vt[3]  = '{1'b0, 4'd9,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001};
      vt[4]  = '{1'b0, 4'd10, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
      vt[5]  = '{1'b0, 4'd15, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
      vt[6]  = '{1'b1, 4'd6,  32'd1,         32'd31,        32'h8000_0000};
      vt[7]  = '{1'b0, 4'd1,  32'd10,        32'd3,         32'h0000_0007};
      vt[8]  = '{1'b1, 4'd11, 32'd7,         32'd7,         32'h0000_0001};
      vt[9]  = '{1'b1, 4'd5,  32'hFFFF_FFFE, 32'd3,         32'h0000_0001};
      vt[10] = '{1'b0, 4'd12, 32'd3,         32'd3,         32'h0000_0000};

      rst1 = 1'b1;
      rst3 = 1'b1;
      a.rsp0_ready = 1'b1; a.rsp1_ready = 1'b1;
      b.rsp0_ready = 1'b1; b.rsp1_ready = 1'b1;
      set_req(1'b0, 1'b1, 4'd0, 32'd1, 32'd2);
      set_req(1'b1, 1'b1, 4'd0, 32'd3, 32'd4);
      b.req0_valid = 1'b0; b.req0_op = 4'd0; b.req0_op1 = 32'd0; b.req0_op2 = 32'd0;
      b.req1_valid = 1'b0; b.req1_op = 4'd0; b.req1_op1 = 32'd0; b.req1_op2 = 32'd0;

      // Reset: outputs quiet while held in reset even with requests pending, and after.
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("reset_ctl", 64'({a.req0_ready, a.req1_ready, a.rsp0_valid, a.rsp1_valid, a.busy}), 64'(0));
      check("reset_alu", {28'd0, a.alu_op, a.alu_op1 | a.alu_op2}, 64'(0));
      check("reset_rsp", {a.rsp0_result, a.rsp1_result}, 64'(0));
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      rst1 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      check("post_reset_ctl", 64'({a.req0_ready, a.req1_ready, a.rsp0_valid, a.rsp1_valid, a.busy}), 64'(0));
      @(posedge clk); #1;

      // Table-driven single ops across all op classes.
      for (int i = 0; i < 11; i++)
         run_op(vt[i].port, vt[i].op, vt[i].x, vt[i].y, vt[i].exp);

      // Contention from reset: both valid continuously, grants must alternate from port 0.
      rst1 = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst1 = 1'b0;
      k0 = 1; k1 = 1; n0 = 0; n1 = 0; pend = 0; pend_v = '0;
      base0 = rsp_cnt0; base1 = rsp_cnt1;
      set_req(1'b0, 1'b1, 4'd0, 32'(k0), 32'd100);
      set_req(1'b1, 1'b1, 4'd6, 32'd1, 32'(k1));
      for (int cyc = 0; cyc < 80 && gq.size() < 6; cyc++) begin
         @(negedge clk);
         if (pend) begin
            check("cont_capture", {a.alu_op1, a.alu_op2}, pend_v);
            pend = 0;
         end
         hp = 2;
         if (a.req0_ready) begin
            gq.push_back(1'b0); n0++; hp = 0; pend = 1;
            pend_v = {32'(k0), 32'd100};
            sbq.push_back('{1'b0, 32'(k0) + 32'd100});
         end else if (a.req1_ready) begin
            gq.push_back(1'b1); n1++; hp = 1; pend = 1;
            pend_v = {32'd1, 32'(k1)};
            sbq.push_back('{1'b1, 32'd1 << k1});
         end
         @(posedge clk); #1;
         if (hp == 0) begin k0++; a.req0_op1 = 32'(k0); end
         else if (hp == 1) begin k1++; a.req1_op2 = 32'(k1); end
      end
      set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      cnt_grants = gq.size();
      check("cont_grant_count", 64'(cnt_grants), 64'(6));
      for (int i = 0; i < cnt_grants; i++)
         check("cont_grant_order", 64'(gq[i]), 64'(i % 2));
      wait_drain("cont_drain");
      check("cont_ready_vs_rsp0", 64'(n0), 64'(rsp_cnt0 - base0));
      check("cont_ready_vs_rsp1", 64'(n1), 64'(rsp_cnt1 - base1));
      @(posedge clk); #1;

      // Backpressure: port 0 response held five cycles while port 1 waits.
      a.rsp0_ready = 1'b0;
      set_req(1'b0, 1'b1, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (a.req0_ready) seen = 1;
      end
      if (!seen) timeout("bp_req0_ready");
      else sbq.push_back('{1'b0, 32'hF000_F000});
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b1, 4'd3, 32'd1, 32'd2);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (a.rsp0_valid) seen = 1;
      end
      if (!seen) timeout("bp_rsp0_valid");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_ctl", 64'({a.rsp0_valid, a.req1_ready, a.busy, a.rsp1_valid}), 64'(4'b1010));
         check("bp_hold_result", 64'(a.rsp0_result), 64'(32'hF000_F000));
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      a.rsp0_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_grant1", 64'({a.req1_ready, a.busy}), 64'(2'b10));
      if (a.req1_ready) sbq.push_back('{1'b1, 32'h0000_0003});
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      wait_drain("bp_drain");
      @(posedge clk); #1;

      // Latency-3 instance: one normal op, latency from ready to response is four cycles.
      b.req0_valid = 1'b1; b.req0_op = 4'd0; b.req0_op1 = 32'd7; b.req0_op2 = 32'd8;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (b.req0_ready) seen = 1;
      end
      if (!seen) timeout("l3_ready");
      @(posedge clk); #1;
      b.req0_valid = 1'b0;
      for (lat = 1; lat < 20; lat++) begin
         @(negedge clk);
         if (b.rsp0_valid) break;
      end
      check("l3_latency", 64'(lat), 64'(4));
      check("l3_result", 64'(b.rsp0_result), 64'(32'd15));
      @(posedge clk); #1;

      // Mid-op reset: abort during the second EXEC cycle of a port 1 op.
      b.req1_valid = 1'b1; b.req1_op = 4'd4; b.req1_op1 = 32'd3; b.req1_op2 = 32'd5;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (b.req1_ready) seen = 1;
      end
      if (!seen) timeout("rst_req1_ready");
      @(posedge clk); #1;
      b.req1_valid = 1'b0;
      @(posedge clk); #1;
      rst3 = 1'b1;
      @(negedge clk);
      check("rst_busy_before", 64'(b.busy), 64'(1));
      @(posedge clk); #1;
      b.req0_valid = 1'b1; b.req0_op = 4'd1; b.req0_op1 = 32'd9; b.req0_op2 = 32'd4;
      b.req1_valid = 1'b1; b.req1_op = 4'd4; b.req1_op1 = 32'd3; b.req1_op2 = 32'd5;
      @(negedge clk);
      check("rst_ctl", 64'({b.req0_ready, b.req1_ready, b.rsp0_valid, b.rsp1_valid, b.busy}), 64'(0));
      check("rst_alu", {28'd0, b.alu_op, b.alu_op1 | b.alu_op2}, 64'(0));
      check("rst_rsp", {b.rsp0_result, b.rsp1_result}, 64'(0));
      @(posedge clk); #1;
      rst3 = 1'b0;
      @(negedge clk);
      check("rst_first_grant", 64'({b.req0_ready, b.req1_ready}), 64'(2'b10));
      @(posedge clk); #1;
      b.req0_valid = 1'b0;
      b.req1_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst_no_stale_rsp1", 64'(b.rsp1_valid), 64'(0));
         if (b.rsp0_valid && !seen) begin
            seen = 1;
            check("rst_next_result", 64'(b.rsp0_result), 64'(32'd5));
         end
      end
      check("rst_next_completed", 64'(seen), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
